// File: rtl/address_encoder.sv
// Address encoder with round-robin arbitration.
// Eight level-sensitive request lines are collected into a pending register
// and turned into one registered 3-bit address. Grants use a valid/ready
// handshake. After each accepted grant there is a single dead cycle, and
// the round-robin pointer then moves just past the address that was taken.

module address_encoder #(
  parameter int NUM_REQ = 8,
  parameter int ADDR_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] reqIn,
  output logic [ADDR_W-1:0]  addOut,
  output logic               addValid,
  input  logic               addReady,
  output logic [NUM_REQ-1:0] pendOut
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } stateT;

  stateT               state;
  stateT               stateNext;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptrNext;
  logic [ADDR_W-1:0]   addOutNext;
  logic                addValidNext;
  logic [NUM_REQ-1:0]  pendNext;
  logic [NUM_REQ-1:0]  clearMask;
  logic [NUM_REQ-1:0]  candidate;
  logic                accept;
  logic [ADDR_W-1:0]   selIdx;
  logic                selFound;
  logic [ADDR_W-1:0]   probe;

  // A handshake completes only while a grant is being presented.
  // addReady on its own does nothing.
  assign accept = addValid & addReady;

  // Live requests are included in the candidate set. This lets a request
  // win in the same cycle it first appears.
  assign candidate = pendOut | reqIn;

  // On an accepted grant, clear that grant's pending bit.
  // A request arriving on the same bit in that cycle sets it again,
  // so the new request wins over the clear.
  always_comb begin
    clearMask = '0;
    if (accept) begin
      clearMask[addOut] = 1'b1;
    end
    pendNext = (pendOut & ~clearMask) | reqIn;
  end

  // Round-robin pick: the first candidate at or above ptr, wrapping to zero.
  always_comb begin
    selIdx   = ptr;
    selFound = 1'b0;
    probe    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = ptr + k[ADDR_W-1:0];
      if (!selFound && candidate[probe]) begin
        selIdx   = probe;
        selFound = 1'b1;
      end
    end
  end

  // Next-state and output logic.
  // GAP holds addValid low for exactly one cycle. On leaving GAP the block
  // makes the same decision as IDLE, so back-to-back requests can reach one
  // grant every two cycles.
  always_comb begin
    stateNext    = state;
    addOutNext   = addOut;
    addValidNext = addValid;
    ptrNext      = ptr;
    case (state)
      IDLE, GAP: begin
        if (en && selFound) begin
          addOutNext   = selIdx;
          addValidNext = 1'b1;
          stateNext    = GRANT;
        end else begin
          addValidNext = 1'b0;
          stateNext    = IDLE;
        end
      end
      GRANT: begin
        if (accept) begin
          ptrNext      = addOut + ADDR_W'(1);
          addValidNext = 1'b0;
          stateNext    = GAP;
        end
      end
      default: begin
        addValidNext = 1'b0;
        stateNext    = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  // Reset takes priority over everything, including an accept in the same
  // cycle, and it drops any grant that is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      addOut   <= '0;
      addValid <= 1'b0;
      pendOut  <= '0;
    end else begin
      state    <= stateNext;
      ptr      <= ptrNext;
      addOut   <= addOutNext;
      addValid <= addValidNext;
      pendOut  <= pendNext;
    end
  end

endmodule

// File: tb/tb_address_encoder.sv
// Self-checking bench for address_encoder.
// A behavioural model predicts each grant and pushes the expected address
// into a queue. A separate monitor pops and compares whenever the DUT
// raises addValid. Directed sequences are followed by randomized traffic.

module tb_address_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] reqIn;
  logic [2:0] addOut;
  logic       addValid;
  logic       addReady;
  logic [7:0] pendOut;

  int checks = 0;
  int passes = 0;
  int expQ[$];

  // Model state: pending set, pointer, whether a grant is outstanding, and
  // the most recently granted address.
  logic [7:0] mPend = '0;
  int         mPtr  = 0;
  bit         mBusy = 1'b0;
  int         mAddr = 0;

  address_encoder #(.NUM_REQ(8), .ADDR_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .reqIn   (reqIn),
    .addOut  (addOut),
    .addValid(addValid),
    .addReady(addReady),
    .pendOut (pendOut)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Apply one clock edge to the model, using the inputs currently driven.
  task automatic modelStep();
    logic [7:0] cand;
    logic [7:0] np;
    int         a;
    if (rst) begin
      mPend = '0;
      mPtr  = 0;
      mBusy = 1'b0;
      mAddr = 0;
      expQ.delete();
    end else begin
      cand = mPend | reqIn;
      np   = mPend;
      if (mBusy && addReady) np[mAddr] = 1'b0;
      np = np | reqIn;
      if (mBusy) begin
        if (addReady) begin
          mBusy = 1'b0;
          mPtr  = (mAddr + 1) % 8;
        end
      end else if (en && cand != 8'h00) begin
        a = mPtr;
        for (int k = 0; k < 8; k++) begin
          if (cand[(mPtr + k) % 8]) begin
            a = (mPtr + k) % 8;
            break;
          end
        end
        mBusy = 1'b1;
        mAddr = a;
        expQ.push_back(a);
      end
      mPend = np;
    end
  endtask

  // Drive one cycle of inputs, step the model on the edge, and return at
  // the following falling edge.
  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] q, input logic rdy);
    rst      = r;
    en       = e;
    reqIn    = q;
    addReady = rdy;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  // Monitor: on each new grant, pop the expected address and compare.
  // Every cycle, also compare the visible state against the model.
  bit prevValid = 1'b0;
  always @(negedge clk) begin
    if (addValid && !prevValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected grant addValid", int'(addValid), 0);
      end else begin
        checkOutput("grant addOut", int'(addOut), expQ.pop_front());
      end
    end else if (expQ.size() != 0) begin
      checkOutput("missing grant addValid", int'(addValid), 1);
      void'(expQ.pop_front());
    end
    checkOutput("addValid", int'(addValid), int'(mBusy));
    checkOutput("addOut", int'(addOut), mAddr);
    checkOutput("pendOut", int'(pendOut), int'(mPend));
    prevValid = addValid;
  end

  initial begin
    rst = 1'b1; en = 1'b0; reqIn = '0; addReady = 1'b0;

    // Reset state
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("reset addOut", int'(addOut), 0);
    checkOutput("reset addValid", int'(addValid), 0);
    checkOutput("reset pendOut", int'(pendOut), 0);

    // Single request on bit 5
    applyStimulus(0, 1, 8'h20, 1);
    checkOutput("single addValid", int'(addValid), 1);
    checkOutput("single addOut", int'(addOut), 5);
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("single pendOut cleared", int'(pendOut), 0);
    checkOutput("single gap addValid", int'(addValid), 0);
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("single idle addValid", int'(addValid), 0);

    // Round robin with all requests held
    applyStimulus(1, 0, 8'h00, 0);
    for (int c = 0; c <= 16; c++) begin
      applyStimulus(0, 1, 8'hFF, 1);
      if (c % 2 == 0) begin
        checkOutput("rr addValid high", int'(addValid), 1);
        checkOutput("rr addOut", int'(addOut), (c / 2) % 8);
      end else begin
        checkOutput("rr addValid low", int'(addValid), 0);
      end
    end

    // Hold under backpressure
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h09, 0);
    for (int c = 0; c < 5; c++) begin
      checkOutput("hold addOut", int'(addOut), 0);
      checkOutput("hold addValid", int'(addValid), 1);
      applyStimulus(0, 1, 8'h00, 0);
    end
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("hold gap addValid", int'(addValid), 0);
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("hold next addOut", int'(addOut), 3);

    // Enable gating
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 0, 8'h84, 1);
    checkOutput("gate addValid", int'(addValid), 0);
    applyStimulus(0, 0, 8'h00, 1);
    checkOutput("gate pendOut", int'(pendOut), 8'h84);
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("gate first addOut", int'(addOut), 2);
    applyStimulus(0, 1, 8'h00, 1);
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("gate second addOut", int'(addOut), 7);
    applyStimulus(0, 1, 8'h00, 1);

    // Wrap and re-request
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h40, 0);
    checkOutput("wrap grant 6", int'(addOut), 6);
    applyStimulus(0, 1, 8'h00, 1);
    applyStimulus(0, 1, 8'h41, 0);
    checkOutput("wrap addOut 0", int'(addOut), 0);
    applyStimulus(0, 1, 8'h00, 1);
    applyStimulus(0, 1, 8'h00, 0);
    checkOutput("wrap regrant 6", int'(addOut), 6);
    applyStimulus(0, 1, 8'h40, 1);
    checkOutput("re-request pendOut bit6", int'(pendOut[6]), 1);
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("re-request addOut", int'(addOut), 6);
    applyStimulus(0, 1, 8'h00, 1);

    // Reset mid-grant
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'h10, 0);
    checkOutput("midgrant addOut", int'(addOut), 4);
    applyStimulus(1, 1, 8'h00, 1);
    checkOutput("midgrant reset addOut", int'(addOut), 0);
    checkOutput("midgrant reset addValid", int'(addValid), 0);
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("midgrant after addValid", int'(addValid), 0);
    applyStimulus(0, 1, 8'h11, 1);
    checkOutput("midgrant ptr zero", int'(addOut), 0);
    applyStimulus(0, 1, 8'h00, 1);

    // Request held through reset
    applyStimulus(1, 1, 8'h08, 0);
    checkOutput("held reset pendOut", int'(pendOut), 0);
    applyStimulus(0, 1, 8'h08, 0);
    checkOutput("held capture addOut", int'(addOut), 3);
    checkOutput("held capture pendOut", int'(pendOut), 8'h08);
    applyStimulus(0, 1, 8'h00, 1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                    $urandom_range(0, 1) == 1);
    end

    for (int c = 0; c < 3; c++) applyStimulus(0, 1, 8'h00, 1);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
